// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
//   Shared definitions for the counter scheduler: the encoding of the per-
//   requester operation field and its width.
// -----------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LOAD = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Free-running down-counter that emits a registered one-cycle tick every
//   DIV_RELOAD+1 clock cycles. It is never gated: hold/auto_en are handled by
//   the consumer.
// Ports
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (counter restarts at DIV_RELOAD)
//   tick     out  one-cycle pulse, raised the cycle after the counter hits 0
// -----------------------------------------------------------------------------
module counter_prescaler #(
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RELOAD = 24'h100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tick_q, tick_d;

  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d  = div_q - DIV_ONE;
    tick_d = 1'b0;
    if (div_q == '0) begin
      div_d  = DIV_RELOAD;
      tick_d = 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= DIV_RELOAD;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//   Scheduler for one shared WIDTH-bit event counter. Each cycle at most one
//   operation is applied, by priority: clear > round-robin granted requester >
//   pending prescaled auto-increment. Boundary events (zero, mid, all-ones) are
//   registered pulses one cycle after the count takes the value, and only when
//   the value actually changed.
// Configuration
//   CNT_SATURATE_EN  defined: INC at all-ones / DEC at zero leave the count
//                    unchanged (no event). Undefined: wrap-around.
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   clear            synchronous clear pulse, highest priority
//   hold             freezes grants and auto-count (pending tick retained)
//   auto_en          enables the prescaled auto-increment
//   req_valid        per-requester pending request
//   req_op           per-requester op (cnt_op_e), OP_W bits each
//   req_data         per-requester LOAD value, WIDTH bits each
//   req_ready        one-hot combinational grant
//   count            current counter value
//   tick             prescaler pulse
//   evt_zero/mid/max one-cycle boundary pulses
//   tick_lost        sticky: an auto tick was dropped
// -----------------------------------------------------------------------------
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int                   NREQ       = 4,
  parameter int                   WIDTH      = 8,
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RELOAD = 24'h100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  hold,
  input  logic                  auto_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [OP_W*NREQ-1:0]  req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  evt_zero,
  output logic                  evt_mid,
  output logic                  evt_max,
  output logic                  tick_lost
);

  localparam int               PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_MID  = CNT_ONE << (WIDTH - 1);

  logic             tick_w;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             auto_pend_q, auto_pend_d;
  logic             tick_lost_q, tick_lost_d;
  logic             changed_q;
  logic             evt_zero_q, evt_mid_q, evt_max_q;

  logic             any_grant;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [NREQ-1:0]  grant;
  cnt_op_e          win_op;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] inc_val, dec_val;
  logic             apply_auto, accept_tick;

  counter_prescaler #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DIV_RELOAD (DIV_RELOAD)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_w)
  );

  // Round-robin scan starting at rr_q. Gated by reset_n so the combinational
  // grant is also quiet while the block is held in reset.
  always_comb begin
    any_grant = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    grant     = '0;
    if (reset_n && !clear && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = PTR_W'((int'(rr_q) + k) % NREQ);
        if (!any_grant && req_valid[scan_idx]) begin
          any_grant = 1'b1;
          win_idx   = scan_idx;
        end
      end
      if (any_grant) grant[win_idx] = 1'b1;
    end
  end

  assign win_op   = cnt_op_e'(req_op[win_idx*OP_W +: OP_W]);
  assign win_data = req_data[win_idx*WIDTH +: WIDTH];

`ifdef CNT_SATURATE_EN
  assign inc_val = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
  assign dec_val = (count_q == '0)      ? count_q : count_q - CNT_ONE;
`else
  assign inc_val = count_q + CNT_ONE;
  assign dec_val = count_q - CNT_ONE;
`endif

  // A pending auto tick is consumed only in a cycle nobody else uses.
  assign apply_auto  = auto_pend_q && !hold && !clear && !any_grant;
  assign accept_tick = tick_w && auto_en && !hold;

  always_comb begin
    count_d     = count_q;
    rr_d        = rr_q;
    auto_pend_d = auto_pend_q;
    tick_lost_d = tick_lost_q;
    if (clear) begin
      count_d     = '0;
      auto_pend_d = 1'b0;
      tick_lost_d = 1'b0;
    end else begin
      if (any_grant) begin
        rr_d = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_ONE;
        case (win_op)
          OP_NOP:  count_d = count_q;
          OP_INC:  count_d = inc_val;
          OP_DEC:  count_d = dec_val;
          OP_LOAD: count_d = win_data;
        endcase
      end else if (apply_auto) begin
        count_d = inc_val;
      end
      // A new tick re-arms the pend when the old one is consumed this cycle;
      // it is only lost when the pend is still waiting.
      if (accept_tick) begin
        if (auto_pend_q && !apply_auto) tick_lost_d = 1'b1;
        auto_pend_d = 1'b1;
      end else if (apply_auto) begin
        auto_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      rr_q        <= '0;
      auto_pend_q <= 1'b0;
      tick_lost_q <= 1'b0;
      changed_q   <= 1'b0;
      evt_zero_q  <= 1'b0;
      evt_mid_q   <= 1'b0;
      evt_max_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      rr_q        <= rr_d;
      auto_pend_q <= auto_pend_d;
      tick_lost_q <= tick_lost_d;
      // Events compare the value the count just took, so they trail the
      // count by one cycle and fire only on an actual change.
      changed_q   <= (count_d != count_q);
      evt_zero_q  <= changed_q && (count_q == '0);
      evt_mid_q   <= changed_q && (count_q == CNT_MID);
      evt_max_q   <= changed_q && (count_q == CNT_MAX);
    end
  end

  assign req_ready = grant;
  assign count     = count_q;
  assign tick      = tick_w;
  assign evt_zero  = evt_zero_q;
  assign evt_mid   = evt_mid_q;
  assign evt_max   = evt_max_q;
  assign tick_lost = tick_lost_q;

endmodule
